// File: rtl/vector_pair_loader_pkg.sv
// Shared definitions for the vector pair loader: FSM state encoding and
// default fixed-point format.
package vector_pair_loader_pkg;

  localparam int DEF_ELEMENT_WIDTH = 32;
  localparam int DEF_DECIMAL_PLACE = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/vector_pair_loader_dot_product.sv
// Fixed-point dot product of two vectors: full-precision sum of products,
// arithmetic shift by DECIMAL_PLACE, wrap to ELEMENT_WIDTH, DOT_LATENCY registers.
module dot_product
  import vector_pair_loader_pkg::*;
#(
  parameter int ELEMENT_WIDTH    = DEF_ELEMENT_WIDTH,
  parameter int DECIMAL_PLACE    = DEF_DECIMAL_PLACE,
  parameter int VECTOR_DIMENSION = 3,
  parameter int DOT_LATENCY      = 1
) (
  input  logic                            clk,
  input  logic                            i_rst,
  input  logic signed [ELEMENT_WIDTH-1:0] i_vec0 [VECTOR_DIMENSION],
  input  logic signed [ELEMENT_WIDTH-1:0] i_vec1 [VECTOR_DIMENSION],
  output logic signed [ELEMENT_WIDTH-1:0] o_product
);

  // Headroom for every full product plus carries of the accumulation.
  localparam int SUM_W = 2*ELEMENT_WIDTH + $clog2(VECTOR_DIMENSION) + 1;

  logic signed [SUM_W-1:0]         w_acc;
  logic signed [ELEMENT_WIDTH-1:0] w_result;

  function automatic logic signed [ELEMENT_WIDTH-1:0] scale_wrap(
    input logic signed [SUM_W-1:0] acc
  );
    logic signed [SUM_W-1:0] shifted;
    shifted = acc >>> DECIMAL_PLACE;
    return shifted[ELEMENT_WIDTH-1:0];
  endfunction

  always_comb begin
    logic signed [SUM_W-1:0] ext_a;
    logic signed [SUM_W-1:0] ext_b;
    w_acc = '0;
    ext_a = '0;
    ext_b = '0;
    for (int i = 0; i < VECTOR_DIMENSION; i++) begin
      ext_a = i_vec0[i];
      ext_b = i_vec1[i];
      w_acc = w_acc + ext_a * ext_b;
    end
  end

  assign w_result = scale_wrap(w_acc);

  generate
    if (DOT_LATENCY == 0) begin : g_comb
      assign o_product = w_result;
    end else begin : g_pipe
      logic signed [ELEMENT_WIDTH-1:0] r_prod_pn [DOT_LATENCY];

      always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < DOT_LATENCY; i++) r_prod_pn[i] <= '0;
        end else begin
          r_prod_pn[0] <= w_result;
          for (int i = 1; i < DOT_LATENCY; i++) r_prod_pn[i] <= r_prod_pn[i-1];
        end
      end

      assign o_product = r_prod_pn[DOT_LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/vector_pair_loader.sv
// Streams two vectors in element by element, runs them through the dot
// product unit and presents the result under a valid/ready handshake.
module vector_pair_loader
  import vector_pair_loader_pkg::*;
#(
  parameter int ELEMENT_WIDTH    = DEF_ELEMENT_WIDTH,
  parameter int DECIMAL_PLACE    = DEF_DECIMAL_PLACE,
  parameter int VECTOR_DIMENSION = 3,
  parameter int DOT_LATENCY      = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [ELEMENT_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            abort,
  output logic signed [ELEMENT_WIDTH-1:0] out_product,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);

  localparam int ELEMS  = 2*VECTOR_DIMENSION;
  localparam int CNT_W  = $clog2(ELEMS);
  localparam int WAIT_W = $clog2(DOT_LATENCY+1) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ELEMS-1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DOT_LATENCY);

  state_t                          r_state;
  logic [CNT_W-1:0]                r_cnt;
  logic [WAIT_W-1:0]               r_wait;
  logic signed [ELEMENT_WIDTH-1:0] r_vec0 [VECTOR_DIMENSION];
  logic signed [ELEMENT_WIDTH-1:0] r_vec1 [VECTOR_DIMENSION];
  logic signed [ELEMENT_WIDTH-1:0] r_product;
  logic                            r_valid;
  logic                            w_rst;
  logic signed [ELEMENT_WIDTH-1:0] w_dot;

  assign w_rst = ~reset;

  dot_product #(
    .ELEMENT_WIDTH   (ELEMENT_WIDTH),
    .DECIMAL_PLACE   (DECIMAL_PLACE),
    .VECTOR_DIMENSION(VECTOR_DIMENSION),
    .DOT_LATENCY     (DOT_LATENCY)
  ) u_dot (
    .clk      (clk),
    .i_rst    (w_rst),
    .i_vec0   (r_vec0),
    .i_vec1   (r_vec1),
    .o_product(w_dot)
  );

  // Abort wins over any accept or handshake; vectors are not cleared on abort,
  // the zeroed counter simply overwrites them on the next load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_LOAD;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_product <= '0;
      r_valid   <= 1'b0;
      for (int i = 0; i < VECTOR_DIMENSION; i++) begin
        r_vec0[i] <= '0;
        r_vec1[i] <= '0;
      end
    end else if (abort) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < VECTOR_DIMENSION; i++) begin
              if (r_cnt == CNT_W'(i))                  r_vec0[i] <= in_data;
              if (r_cnt == CNT_W'(i+VECTOR_DIMENSION)) r_vec1[i] <= in_data;
            end
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_wait  <= '0;
              r_state <= ST_ISSUE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (r_wait == WAIT_LAST) begin
            r_product <= w_dot;
            r_valid   <= 1'b1;
            r_state   <= ST_RESULT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_LOAD);
  assign busy        = !((r_state == ST_LOAD) && (r_cnt == '0));
  assign out_valid   = r_valid;
  assign out_product = r_product;

endmodule

// File: doc/vector_pair_loader.md
VECTOR_PAIR_LOADER -- requirements
Module: vector_pair_loader

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 32, signed fixed-point element and result width.
REQ-002 SHALL have parameter DECIMAL_PLACE, default 8, number of fractional bits.
REQ-003 SHALL have parameter VECTOR_DIMENSION, default 3, elements per vector.
REQ-004 SHALL have parameter DOT_LATENCY, default 1, registered latency of the dot_product sub-module in cycles.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 in_data  input  ELEMENT_WIDTH  signed element stream; vec0 elements first, then vec1.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts an element this cycle.
REQ-010 abort  input  1  synchronous flush of any partial load or pending result.
REQ-011 out_product  output  ELEMENT_WIDTH  signed dot product of the loaded pair.
REQ-012 out_valid  output  1  out_product is valid.
REQ-013 out_ready  input  1  consumer accepts out_product.
REQ-014 busy  output  1  high in any state other than LOAD with element count 0.

Function
REQ-015 SHALL implement states LOAD, ISSUE and RESULT.
REQ-016 in_ready SHALL be 1 in LOAD and 0 in ISSUE and RESULT.
REQ-017 An element SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
- Accepted element k, for k < VECTOR_DIMENSION, SHALL be written to vec0[k].
- Otherwise it SHALL be written to vec1[k-VECTOR_DIMENSION].
REQ-018 The element counter SHALL run 0..2*VECTOR_DIMENSION-1 and SHALL hold while in_valid is 0.
REQ-019 Accepting element 2*VECTOR_DIMENSION-1 SHALL move LOAD->ISSUE, reset the counter to 0, and freeze vec0/vec1.
REQ-020 ISSUE SHALL last DOT_LATENCY+1 cycles (wait counter).
- On its final edge the loader SHALL register the sub-module product into out_product and move to RESULT.
REQ-021 out_valid SHALL rise exactly DOT_LATENCY+1 cycles after the last accepting edge.
REQ-022 In RESULT, out_valid and out_product SHALL hold stable until an edge with out_ready=1.
- That edge SHALL move RESULT->LOAD; out_valid SHALL fall and in_ready SHALL rise in the following cycle.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 Arithmetic SHALL be the dot_product rule: sum over i of (vec0[i]*vec1[i]) >>> DECIMAL_PLACE, full-precision products, two's-complement wrap to ELEMENT_WIDTH, no saturation.
REQ-025 abort=1 SHALL, on the next edge, in any state:
- force LOAD with counter 0;
- clear out_valid;
- discard partial vectors.
abort SHALL take priority over a simultaneous element accept or out_ready.
REQ-026 vec0/vec1 contents SHALL NOT change outside LOAD accepts.

Reset
REQ-027 reset=0 SHALL immediately force state LOAD, counters 0, vec0/vec1 all 0, out_product 0, out_valid 0, busy 0, and in_ready 1 once reset is released.
REQ-028 Reset SHALL be drivable mid-load or mid-result and SHALL discard all in-flight data.
REQ-029 The dot_product sub-module SHALL receive an active-high reset derived as the inverse of reset.

Structure
REQ-030 A shared package SHALL hold the state enum (LOAD, ISSUE, RESULT) and the default fixed-point constants (ELEMENT_WIDTH=32, DECIMAL_PLACE=8).
REQ-031 The block SHALL instantiate exactly one dot_product sub-module, fed by the registered vec0/vec1 arrays.

Verification
REQ-032 Stream 0x1080, 0xABC0, 0x694D, 0xDD00, 0xDFF8, 0x3416 with out_ready=1 -> out_product=0x00B9EDD2, out_valid high 2 cycles after the last accept.
REQ-033 Same stream with element 0 = 0xFFFFEF80 -> out_product=0x009D70D2.
REQ-034 Insert in_valid gaps between elements and hold out_ready=0 for 5 cycles -> the result matches REQ-032, out_valid/out_product stay stable throughout, and in_ready=0 until the handshake.
REQ-035 Pulse abort after 4 accepted elements, then send the REQ-032 stream -> out_product=0x00B9EDD2, with no stale elements in the result.
REQ-036 Drive reset=0 while in RESULT -> out_valid=0 and out_product=0 immediately; after release, a full stream yields the correct result.
REQ-037 Assert abort and out_ready together in RESULT -> LOAD, out_valid=0, and no second result.
